// File: rtl/sm_register_sync_pkg.sv
// -----------------------------------------------------------------------------
// sm_register_sync_pkg
// Shared constants for the sm_register_sync storage register.
//   XLEN        : CPU datapath width, default width of the register
//   STAGES_MIN  : smallest supported pipeline depth
//   STAGES_MAX  : largest supported pipeline depth
//   stages_legal: elaboration-time range check on the depth parameter
// -----------------------------------------------------------------------------
package sm_register_sync_pkg;

  localparam int XLEN       = 32;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 16;

  typedef logic [XLEN-1:0] xlen_t;

  function automatic bit stages_legal(input int stages);
    return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
  endfunction

endpackage

// File: rtl/sm_register_sync_if.sv
// -----------------------------------------------------------------------------
// sm_register_sync_if
// Data bundle between a producer and the storage register.
//   d : data to capture (producer -> register)
//   q : registered data  (register -> consumer)
// Modports: master drives d and observes q; slave is the register side.
// -----------------------------------------------------------------------------
interface sm_register_sync_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (output d, input  q);
  modport slave  (input  d, output q);

endinterface

// File: rtl/sm_register_sync_core.sv
// -----------------------------------------------------------------------------
// sm_register_sync_core
// STAGES-deep chain of D flops with synchronous, active-high reset.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, ACTIVE-HIGH despite the legacy name (1 = reset)
//   bus   : slave side of sm_register_sync_if (bus.d in, bus.q out)
// -----------------------------------------------------------------------------
module sm_register_sync_core
  import sm_register_sync_pkg::*;
#(
  parameter int               WIDTH       = XLEN,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               STAGES      = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  sm_register_sync_if.slave   bus
);

  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("sm_register_sync_core: STAGES=%0d outside supported range 1..16", STAGES);
  end

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = bus.d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Reset takes priority over data on the same edge and flushes every stage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (rst_n) begin
        stage_q[i] <= RESET_VALUE;
      end else begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign bus.q = stage_q[STAGES-1];

endmodule

// File: rtl/sm_register_sync.sv
// -----------------------------------------------------------------------------
// sm_register_sync
// Parameterised D-type storage register (program counter, delay line).
// Plain ports are kept in the order clk, rst_n, d, q so existing positional
// instantiations still connect.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, ACTIVE-HIGH (1 = load RESET_VALUE)
//   d     : data captured every clock edge (no enable; hold = feed q back)
//   q     : last stage, STAGES edges behind d, driven only by flops
// -----------------------------------------------------------------------------
module sm_register_sync
  import sm_register_sync_pkg::*;
#(
  parameter int               WIDTH       = XLEN,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               STAGES      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  sm_register_sync_if #(.WIDTH(WIDTH)) bus ();

  assign bus.d = d;
  assign q     = bus.q;

  sm_register_sync_core #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE),
    .STAGES      (STAGES)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

endmodule

// File: tb/tb_sm_register_sync.sv
module tb_sm_register_sync;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sm_register_sync_if #(.WIDTH(32)) b32  ();
  sm_register_sync_if #(.WIDTH(32)) b100 ();
  sm_register_sync_if #(.WIDTH(32)) b3   ();
  sm_register_sync_if #(.WIDTH(1))  b1   ();
  sm_register_sync_if #(.WIDTH(64)) b64  ();

  sm_register_sync #(.WIDTH(32)) u_def (
    .clk(clk), .rst_n(rst_n), .d(b32.d), .q(b32.q));

  sm_register_sync #(.WIDTH(32), .RESET_VALUE(32'h0000_0100)) u_rv (
    .clk(clk), .rst_n(rst_n), .d(b100.d), .q(b100.q));

  sm_register_sync #(.WIDTH(32), .STAGES(3)) u_pipe (
    .clk(clk), .rst_n(rst_n), .d(b3.d), .q(b3.q));

  sm_register_sync #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .d(b1.d), .q(b1.q));

  sm_register_sync #(.WIDTH(64)) u_w64 (
    .clk(clk), .rst_n(rst_n), .d(b64.d), .q(b64.q));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    b32.d  = 32'hDEAD_BEEF;
    b100.d = 32'hDEAD_BEEF;
    b3.d   = 32'hDEAD_BEEF;
    b1.d   = 1'b1;
    b64.d  = '1;
    step();
    checks++; if (b32.q !== 32'h0) begin errors++; $display("FAIL reset_q32 got %h exp %h", b32.q, 32'h0); end
    checks++; if (b100.q !== 32'h100) begin errors++; $display("FAIL reset_rv got %h exp %h", b100.q, 32'h100); end
    checks++; if (b3.q !== 32'h0) begin errors++; $display("FAIL reset_pipe got %h exp %h", b3.q, 32'h0); end
    checks++; if (b1.q !== 1'b0) begin errors++; $display("FAIL reset_w1 got %b exp %b", b1.q, 1'b0); end
    checks++; if (b64.q !== 64'h0) begin errors++; $display("FAIL reset_w64 got %h exp %h", b64.q, 64'h0); end
    step();
    checks++; if (b32.q !== 32'h0) begin errors++; $display("FAIL reset_hold got %h exp %h", b32.q, 32'h0); end
    rst_n = 1'b0;
    b32.d = 32'h0000_0008;
    step();
    checks++; if (b32.q !== 32'h8) begin errors++; $display("FAIL reset_release got %h exp %h", b32.q, 32'h8); end
  endtask

  task automatic test_stream();
    logic [31:0] seq [4];
    logic [31:0] prev;
    seq[0] = 32'h0; seq[1] = 32'h8; seq[2] = 32'h10; seq[3] = 32'h18;
    prev = 32'h8;
    for (int i = 0; i < 4; i++) begin
      b32.d = seq[i];
      #1;
      checks++; if (b32.q !== prev) begin errors++; $display("FAIL stream_pre[%0d] got %h exp %h", i, b32.q, prev); end
      step();
      checks++; if (b32.q !== seq[i]) begin errors++; $display("FAIL stream[%0d] got %h exp %h", i, b32.q, seq[i]); end
      prev = seq[i];
    end
  endtask

  task automatic test_precedence();
    b100.d = 32'h0000_1234;
    step();
    checks++; if (b100.q !== 32'h1234) begin errors++; $display("FAIL prec_load got %h exp %h", b100.q, 32'h1234); end
    rst_n  = 1'b1;
    b100.d = 32'hFFFF_FFFF;
    b32.d  = 32'hFFFF_FFFF;
    step();
    checks++; if (b100.q !== 32'h100) begin errors++; $display("FAIL prec_rv got %h exp %h", b100.q, 32'h100); end
    checks++; if (b32.q !== 32'h0) begin errors++; $display("FAIL prec_def got %h exp %h", b32.q, 32'h0); end
    rst_n = 1'b0;
  endtask

  task automatic test_async_pulse();
    b32.d = 32'h55;
    step();
    checks++; if (b32.q !== 32'h55) begin errors++; $display("FAIL pulse_setup got %h exp %h", b32.q, 32'h55); end
    #2 rst_n = 1'b1;
    #1;
    checks++; if (b32.q !== 32'h55) begin errors++; $display("FAIL pulse_during got %h exp %h", b32.q, 32'h55); end
    #2 rst_n = 1'b0;
    step();
    checks++; if (b32.q !== 32'h55) begin errors++; $display("FAIL pulse_after got %h exp %h", b32.q, 32'h55); end
  endtask

  task automatic test_pipeline();
    logic [31:0] exp_q [6];
    logic [31:0] flush_exp [3];
    exp_q[0] = 0; exp_q[1] = 0; exp_q[2] = 1; exp_q[3] = 2; exp_q[4] = 3; exp_q[5] = 4;
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b3.d = 32'(i + 1);
      step();
      checks++; if (b3.q !== exp_q[i]) begin errors++; $display("FAIL pipe[%0d] got %h exp %h", i, b3.q, exp_q[i]); end
    end
    rst_n = 1'b1;
    b3.d  = 32'h7;
    step();
    checks++; if (b3.q !== 32'h0) begin errors++; $display("FAIL pipe_flush got %h exp %h", b3.q, 32'h0); end
    rst_n = 1'b0;
    flush_exp[0] = 32'h0; flush_exp[1] = 32'h0; flush_exp[2] = 32'h8;
    for (int i = 0; i < 3; i++) begin
      b3.d = 32'(8 + i);
      step();
      checks++; if (b3.q !== flush_exp[i]) begin errors++; $display("FAIL pipe_post[%0d] got %h exp %h", i, b3.q, flush_exp[i]); end
    end
  endtask

  task automatic test_width();
    logic [63:0] pat64 [5];
    logic        pat1  [5];
    pat64[0] = '0; pat64[1] = '1; pat64[2] = '0; pat64[3] = '1; pat64[4] = 64'hA5A5_5A5A_0F0F_F0F0;
    pat1[0]  = 0;  pat1[1]  = 1;  pat1[2]  = 0;  pat1[3]  = 1;  pat1[4]  = 0;
    for (int i = 0; i < 5; i++) begin
      b64.d = pat64[i];
      b1.d  = pat1[i];
      step();
      checks++; if (b64.q !== pat64[i]) begin errors++; $display("FAIL w64[%0d] got %h exp %h", i, b64.q, pat64[i]); end
      checks++; if (b1.q !== pat1[i]) begin errors++; $display("FAIL w1[%0d] got %b exp %b", i, b1.q, pat1[i]); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    b32.d  = '0;
    b100.d = '0;
    b3.d   = '0;
    b1.d   = '0;
    b64.d  = '0;
    test_reset();
    test_stream();
    test_precedence();
    test_async_pulse();
    test_pipeline();
    test_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
